mor1kx_spr_arbiter: RTL and testbench

Shares the single SPR bus between two requesters, the CPU pipeline (core) and the debug unit (du), and sequences each access to the DMMU, IMMU, DC or IC slave. It sits between the requesters and the slave SPR ports, after the core's SPR request logic.
- Decodes the SPR group.
- Holds address, write-enable and data stable for the whole access.
- Routes back only the acknowledge of the selected slave.
- Converts unmapped groups and unanswered accesses into a one-cycle error response.

---
 rtl/mor1kx_spr_arbiter_if.sv | 60 ++++++
 rtl/mor1kx_spr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mor1kx_spr_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_spr_arbiter_if.sv
// Requester, SPR-bus and status signals of mor1kx_spr_arbiter bundled into one interface.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mor1kx_spr_arbiter_if #(
    parameter int OPTION_OPERAND_WIDTH = 32
);
    logic [15:0]                     core_addr_i;
    logic                            core_we_i;
    logic                            core_stb_i;
    logic [OPTION_OPERAND_WIDTH-1:0] core_dat_i;
    logic                            core_ack_o;
    logic                            core_err_o;
    logic [OPTION_OPERAND_WIDTH-1:0] core_dat_o;

    logic [15:0]                     du_addr_i;
    logic                            du_we_i;
    logic                            du_stb_i;
    logic [OPTION_OPERAND_WIDTH-1:0] du_dat_i;
    logic                            du_ack_o;
    logic                            du_err_o;
    logic [OPTION_OPERAND_WIDTH-1:0] du_dat_o;

    logic [15:0]                     spr_bus_addr_o;
    logic                            spr_bus_we_o;
    logic                            spr_bus_stb_o;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o;

    logic                            spr_bus_ack_dmmu_i;
    logic                            spr_bus_ack_immu_i;
    logic                            spr_bus_ack_dc_i;
    logic                            spr_bus_ack_ic_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_dmmu_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_immu_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_dc_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_ic_i;

    logic                            busy_o;
    logic                            grant_du_o;

    modport slave (
        input  core_addr_i, core_we_i, core_stb_i, core_dat_i,
        output core_ack_o, core_err_o, core_dat_o,
        input  du_addr_i, du_we_i, du_stb_i, du_dat_i,
        output du_ack_o, du_err_o, du_dat_o,
        output spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
        input  spr_bus_ack_dmmu_i, spr_bus_ack_immu_i, spr_bus_ack_dc_i, spr_bus_ack_ic_i,
        input  spr_bus_dat_dmmu_i, spr_bus_dat_immu_i, spr_bus_dat_dc_i, spr_bus_dat_ic_i,
        output busy_o, grant_du_o
    );

    modport master (
        output core_addr_i, core_we_i, core_stb_i, core_dat_i,
        input  core_ack_o, core_err_o, core_dat_o,
        output du_addr_i, du_we_i, du_stb_i, du_dat_i,
        input  du_ack_o, du_err_o, du_dat_o,
        input  spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
        output spr_bus_ack_dmmu_i, spr_bus_ack_immu_i, spr_bus_ack_dc_i, spr_bus_ack_ic_i,
        output spr_bus_dat_dmmu_i, spr_bus_dat_immu_i, spr_bus_dat_dc_i, spr_bus_dat_ic_i,
        input  busy_o, grant_du_o
    );
endinterface

// File: rtl/mor1kx_spr_arbiter.sv
// Round-robin arbiter sharing the SPR bus between core and debug unit; decodes the SPR
// group, holds the access stable, returns the selected slave's ack or a one-cycle error.
module mor1kx_spr_arbiter #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT              = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mor1kx_spr_arbiter_if.slave  bus
);

    localparam int W = OPTION_OPERAND_WIDTH;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    // Encoding equals SPR group number minus one.
    typedef enum logic [1:0] {
        SEL_DMMU,
        SEL_IMMU,
        SEL_DC,
        SEL_IC
    } sel_e;

    state_e         state_q, state_d;
    sel_e           sel_q, sel_d;
    logic [15:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [W-1:0]   wdat_q, wdat_d;
    logic           stb_q, stb_d;
    logic           grant_du_q, grant_du_d;
    logic           resp_ok_q, resp_ok_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [W-1:0]   core_rdat_q, core_rdat_d;
    logic [W-1:0]   du_rdat_q, du_rdat_d;

    // grant_du_q doubles as the round-robin pointer: on a tie the other requester wins.
    logic           pick_du;
    logic [15:0]    req_addr;
    logic           req_we;
    logic [W-1:0]   req_dat;
    logic [4:0]     req_group;
    logic           req_mapped;
    sel_e           req_sel;

    assign pick_du    = bus.du_stb_i & (~bus.core_stb_i | ~grant_du_q);
    assign req_addr   = pick_du ? bus.du_addr_i : bus.core_addr_i;
    assign req_we     = pick_du ? bus.du_we_i   : bus.core_we_i;
    assign req_dat    = pick_du ? bus.du_dat_i  : bus.core_dat_i;
    assign req_group  = req_addr[15:11];
    assign req_mapped = (req_group >= 5'd1) && (req_group <= 5'd4);
    assign req_sel    = sel_e'(2'(req_group - 5'd1));

    logic           sel_ack;
    logic [W-1:0]   sel_dat;

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        case (sel_q)
            SEL_DMMU: begin sel_ack = bus.spr_bus_ack_dmmu_i; sel_dat = bus.spr_bus_dat_dmmu_i; end
            SEL_IMMU: begin sel_ack = bus.spr_bus_ack_immu_i; sel_dat = bus.spr_bus_dat_immu_i; end
            SEL_DC:   begin sel_ack = bus.spr_bus_ack_dc_i;   sel_dat = bus.spr_bus_dat_dc_i;   end
            SEL_IC:   begin sel_ack = bus.spr_bus_ack_ic_i;   sel_dat = bus.spr_bus_dat_ic_i;   end
            default:  ;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdat_d      = wdat_q;
        stb_d       = stb_q;
        grant_du_d  = grant_du_q;
        resp_ok_d   = resp_ok_q;
        cnt_d       = cnt_q;
        core_rdat_d = core_rdat_q;
        du_rdat_d   = du_rdat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.core_stb_i || bus.du_stb_i) begin
                    addr_d     = req_addr;
                    we_d       = req_we;
                    wdat_d     = req_dat;
                    sel_d      = req_sel;
                    grant_du_d = pick_du;
                    cnt_d      = '0;
                    if (req_mapped) begin
                        state_d = S_BUS;
                        stb_d   = 1'b1;
                    end else begin
                        state_d   = S_RESP;
                        resp_ok_d = 1'b0;
                        if (pick_du) du_rdat_d   = '0;
                        else         core_rdat_d = '0;
                    end
                end
            end

            S_BUS: begin
                // An ack arriving on the last permitted cycle still beats the timeout.
                if (sel_ack) begin
                    state_d   = S_RESP;
                    stb_d     = 1'b0;
                    resp_ok_d = 1'b1;
                    if (grant_du_q) du_rdat_d   = sel_dat;
                    else            core_rdat_d = sel_dat;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RESP;
                    stb_d     = 1'b0;
                    resp_ok_d = 1'b0;
                    if (grant_du_q) du_rdat_d   = '0;
                    else            core_rdat_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= SEL_DMMU;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdat_q      <= '0;
            stb_q       <= 1'b0;
            grant_du_q  <= 1'b0;
            resp_ok_q   <= 1'b0;
            cnt_q       <= '0;
            core_rdat_q <= '0;
            du_rdat_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdat_q      <= wdat_d;
            stb_q       <= stb_d;
            grant_du_q  <= grant_du_d;
            resp_ok_q   <= resp_ok_d;
            cnt_q       <= cnt_d;
            core_rdat_q <= core_rdat_d;
            du_rdat_q   <= du_rdat_d;
        end
    end

    logic in_resp;
    assign in_resp = (state_q == S_RESP);

    assign bus.core_ack_o = in_resp &  resp_ok_q & ~grant_du_q;
    assign bus.core_err_o = in_resp & ~resp_ok_q & ~grant_du_q;
    assign bus.du_ack_o   = in_resp &  resp_ok_q &  grant_du_q;
    assign bus.du_err_o   = in_resp & ~resp_ok_q &  grant_du_q;
    assign bus.core_dat_o = core_rdat_q;
    assign bus.du_dat_o   = du_rdat_q;

    assign bus.spr_bus_addr_o = addr_q;
    assign bus.spr_bus_we_o   = we_q;
    assign bus.spr_bus_stb_o  = stb_q;
    assign bus.spr_bus_dat_o  = wdat_q;

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.grant_du_o = grant_du_q;

endmodule

// File: tb/tb_mor1kx_spr_arbiter.sv
// Directed bench for mor1kx_spr_arbiter: reset values, read, tie-break, unmapped,
// timeout, ack filtering and reset during a bus cycle.
module tb_mor1kx_spr_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mor1kx_spr_arbiter_if #(.OPTION_OPERAND_WIDTH(32)) spr_if ();

    mor1kx_spr_arbiter #(
        .OPTION_OPERAND_WIDTH(32),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (spr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        spr_if.core_addr_i = '0; spr_if.core_we_i = 1'b0; spr_if.core_stb_i = 1'b0; spr_if.core_dat_i = '0;
        spr_if.du_addr_i   = '0; spr_if.du_we_i   = 1'b0; spr_if.du_stb_i   = 1'b0; spr_if.du_dat_i   = '0;
        spr_if.spr_bus_ack_dmmu_i = 1'b0; spr_if.spr_bus_ack_immu_i = 1'b0;
        spr_if.spr_bus_ack_dc_i   = 1'b0; spr_if.spr_bus_ack_ic_i   = 1'b0;
        spr_if.spr_bus_dat_dmmu_i = '0; spr_if.spr_bus_dat_immu_i = '0;
        spr_if.spr_bus_dat_dc_i   = '0; spr_if.spr_bus_dat_ic_i   = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi_cycles;
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset values
        #12;
        check("rst_stb",   {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        check("rst_we",    {31'd0, spr_if.spr_bus_we_o},  32'd0);
        check("rst_busy",  {31'd0, spr_if.busy_o},        32'd0);
        check("rst_grant", {31'd0, spr_if.grant_du_o},    32'd0);
        check("rst_addr",  {16'd0, spr_if.spr_bus_addr_o}, 32'd0);
        check("rst_bdat",  spr_if.spr_bus_dat_o, 32'd0);
        check("rst_cdat",  spr_if.core_dat_o,    32'd0);
        check("rst_ddat",  spr_if.du_dat_o,      32'd0);
        check("rst_pulses", {28'd0, spr_if.core_ack_o, spr_if.core_err_o, spr_if.du_ack_o, spr_if.du_err_o}, 32'd0);
        rst_n = 1'b1;

        // Core read of DMMU 0x0800, ack on 2nd stb cycle
        spr_if.core_addr_i = 16'h0800;
        spr_if.core_stb_i  = 1'b1;
        tick();
        check("rd_stb1",  {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        check("rd_addr",  {16'd0, spr_if.spr_bus_addr_o}, 32'h0800);
        check("rd_we",    {31'd0, spr_if.spr_bus_we_o}, 32'd0);
        check("rd_busy",  {31'd0, spr_if.busy_o}, 32'd1);
        check("rd_gdu",   {31'd0, spr_if.grant_du_o}, 32'd0);
        tick();
        check("rd_stb2",  {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        check("rd_noack", {31'd0, spr_if.core_ack_o}, 32'd0);
        spr_if.spr_bus_ack_dmmu_i = 1'b1;
        spr_if.spr_bus_dat_dmmu_i = 32'hDEADBEEF;
        tick();
        check("rd_ack",   {31'd0, spr_if.core_ack_o}, 32'd1);
        check("rd_err",   {31'd0, spr_if.core_err_o}, 32'd0);
        check("rd_dat",   spr_if.core_dat_o, 32'hDEADBEEF);
        check("rd_stb3",  {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        check("rd_du",    {30'd0, spr_if.du_ack_o, spr_if.du_err_o}, 32'd0);
        spr_if.spr_bus_ack_dmmu_i = 1'b0;
        spr_if.core_stb_i = 1'b0;
        tick();
        check("rd_ack_1p", {31'd0, spr_if.core_ack_o}, 32'd0);
        check("rd_idle",   {31'd0, spr_if.busy_o}, 32'd0);
        check("rd_hold",   spr_if.core_dat_o, 32'hDEADBEEF);

        // Simultaneous request right after reset: du first, then core
        pulse_reset();
        spr_if.core_addr_i = 16'h1000;
        spr_if.du_addr_i   = 16'h1800;
        spr_if.core_stb_i  = 1'b1;
        spr_if.du_stb_i    = 1'b1;
        tick();
        check("tie_gdu1",  {31'd0, spr_if.grant_du_o}, 32'd1);
        check("tie_addr1", {16'd0, spr_if.spr_bus_addr_o}, 32'h1800);
        spr_if.spr_bus_ack_dc_i = 1'b1;
        spr_if.spr_bus_dat_dc_i = 32'h11112222;
        tick();
        check("tie_duack", {31'd0, spr_if.du_ack_o}, 32'd1);
        check("tie_ddat",  spr_if.du_dat_o, 32'h11112222);
        check("tie_cack0", {31'd0, spr_if.core_ack_o}, 32'd0);
        spr_if.spr_bus_ack_dc_i = 1'b0;
        spr_if.du_stb_i = 1'b0;
        tick();
        check("tie_duack_1p", {31'd0, spr_if.du_ack_o}, 32'd0);
        check("tie_gap",      {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        tick();
        check("tie_gdu0",  {31'd0, spr_if.grant_du_o}, 32'd0);
        check("tie_addr2", {16'd0, spr_if.spr_bus_addr_o}, 32'h1000);
        spr_if.spr_bus_ack_immu_i = 1'b1;
        spr_if.spr_bus_dat_immu_i = 32'h33334444;
        tick();
        check("tie_cack",  {31'd0, spr_if.core_ack_o}, 32'd1);
        check("tie_cdat",  spr_if.core_dat_o, 32'h33334444);
        check("tie_dack0", {31'd0, spr_if.du_ack_o}, 32'd0);
        spr_if.spr_bus_ack_immu_i = 1'b0;
        spr_if.core_stb_i = 1'b0;
        tick();
        check("tie_cack_1p", {31'd0, spr_if.core_ack_o}, 32'd0);

        // du write to unmapped group 5
        spr_if.du_addr_i = 16'h2800;
        spr_if.du_we_i   = 1'b1;
        spr_if.du_dat_i  = 32'hCAFEF00D;
        spr_if.du_stb_i  = 1'b1;
        tick();
        check("um_err",   {31'd0, spr_if.du_err_o}, 32'd1);
        check("um_ack",   {31'd0, spr_if.du_ack_o}, 32'd0);
        check("um_stb",   {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        check("um_ddat",  spr_if.du_dat_o, 32'd0);
        check("um_core",  {30'd0, spr_if.core_ack_o, spr_if.core_err_o}, 32'd0);
        spr_if.du_stb_i = 1'b0;
        spr_if.du_we_i  = 1'b0;
        tick();
        check("um_err_1p", {31'd0, spr_if.du_err_o}, 32'd0);
        check("um_stb2",   {31'd0, spr_if.spr_bus_stb_o}, 32'd0);

        // Core write to DC with no ack: timeout after 16 stb cycles
        spr_if.core_addr_i = 16'h1800;
        spr_if.core_we_i   = 1'b1;
        spr_if.core_dat_i  = 32'h55AA55AA;
        spr_if.core_stb_i  = 1'b1;
        tick();
        spr_if.core_dat_i  = 32'h0;
        check("to_bdat", spr_if.spr_bus_dat_o, 32'h55AA55AA);
        check("to_bwe",  {31'd0, spr_if.spr_bus_we_o}, 32'd1);
        hi_cycles = 0;
        while (spr_if.spr_bus_stb_o && hi_cycles < 40) begin
            hi_cycles++;
            tick();
        end
        check("to_cycles", hi_cycles, 32'd16);
        check("to_err",    {31'd0, spr_if.core_err_o}, 32'd1);
        check("to_ack",    {31'd0, spr_if.core_ack_o}, 32'd0);
        check("to_cdat",   spr_if.core_dat_o, 32'd0);
        spr_if.core_stb_i = 1'b0;
        spr_if.core_we_i  = 1'b0;
        tick();
        check("to_idle",   {31'd0, spr_if.busy_o}, 32'd0);
        check("to_err_1p", {31'd0, spr_if.core_err_o}, 32'd0);

        // Core read of IC with IMMU and DC acks stuck high
        spr_if.spr_bus_ack_immu_i = 1'b1;
        spr_if.spr_bus_dat_immu_i = 32'hAAAA0001;
        spr_if.spr_bus_ack_dc_i   = 1'b1;
        spr_if.spr_bus_dat_dc_i   = 32'hBBBB0002;
        spr_if.spr_bus_dat_ic_i   = 32'h1C1C1C1C;
        spr_if.core_addr_i = 16'h2000;
        spr_if.core_stb_i  = 1'b1;
        tick();
        check("ic_stb1", {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        tick();
        check("ic_stb2", {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        check("ic_noack2", {31'd0, spr_if.core_ack_o}, 32'd0);
        tick();
        check("ic_stb3", {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        spr_if.spr_bus_ack_ic_i = 1'b1;
        tick();
        check("ic_ack", {31'd0, spr_if.core_ack_o}, 32'd1);
        check("ic_dat", spr_if.core_dat_o, 32'h1C1C1C1C);
        check("ic_stb_off", {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        clear_inputs();
        tick();

        // Reset asserted during BUS, then a fresh access
        spr_if.du_addr_i = 16'h0800;
        spr_if.du_stb_i  = 1'b1;
        tick();
        check("mr_stb_pre", {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_stb_now", {31'd0, spr_if.spr_bus_stb_o}, 32'd0);
        check("mr_busy",    {31'd0, spr_if.busy_o}, 32'd0);
        spr_if.du_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_pulses", {28'd0, spr_if.core_ack_o, spr_if.core_err_o, spr_if.du_ack_o, spr_if.du_err_o}, 32'd0);
        check("mr_gdu",    {31'd0, spr_if.grant_du_o}, 32'd0);
        spr_if.core_addr_i = 16'h1000;
        spr_if.core_stb_i  = 1'b1;
        tick();
        check("mr_new_stb",  {31'd0, spr_if.spr_bus_stb_o}, 32'd1);
        check("mr_new_addr", {16'd0, spr_if.spr_bus_addr_o}, 32'h1000);
        spr_if.spr_bus_ack_immu_i = 1'b1;
        spr_if.spr_bus_dat_immu_i = 32'h0BADF00D;
        tick();
        check("mr_new_ack", {31'd0, spr_if.core_ack_o}, 32'd1);
        check("mr_new_dat", spr_if.core_dat_o, 32'h0BADF00D);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
